// File: rtl/turbo_pkg.sv
// Shared constants, interleaver permutation, RSC state type and trellis helpers
// for the rate-1/3 turbo encoder front end.
package turbo_pkg;

  localparam int BYTE_W  = 32'sd8;
  localparam int RSC_MEM = 32'sd2;

  // Bit-reversal of the 3-bit index: intr[i] = data[INTR_PERM[i]]
  localparam logic [2:0] INTR_PERM [0:BYTE_W-1] =
    '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  typedef struct packed {
    logic s1;
    logic s2;
  } rsc_state_t;

  function automatic logic [BYTE_W-1:0] interleave(input logic [BYTE_W-1:0] d);
    logic [BYTE_W-1:0] r;
    r = '0;
    for (int i = 32'sd0; i < BYTE_W; i++) begin
      r[i] = d[INTR_PERM[i]];
    end
    return r;
  endfunction

  function automatic logic rsc_feedback(input logic u, input rsc_state_t s);
    return u ^ s.s1 ^ s.s2;
  endfunction

  function automatic logic rsc_parity(input logic u, input rsc_state_t s);
    return rsc_feedback(u, s) ^ s.s2;
  endfunction

endpackage

// File: rtl/turbo_encoder_top_rsc.sv
// Recursive systematic convolutional encoder, feedback 1+D+D^2, feedforward 1+D^2.
// Clear has priority over the state update on the same edge.
import turbo_pkg::*;

module rsc_encoder (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic u,
  output logic parity
);

  rsc_state_t state_r;

  // trellis state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= '0;
    end else if (clear) begin
      state_r <= '0;
    end else if (enable) begin
      state_r <= '{s1: rsc_feedback(u, state_r), s2: state_r.s1};
    end else begin
      state_r <= state_r;
    end
  end

  assign parity = rsc_parity(u, state_r);

endmodule

// File: rtl/turbo_encoder_top.sv
// Turbo encoder front end: deserialise, interleave, re-serialise, two RSC encoders.
// Optional macro TURBO_TRELLIS_RESET_EN restarts both trellises from zero on every byte load.
import turbo_pkg::*;

module turbo_encoder_top (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [BYTE_W-1:0] data_out,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] intr,
  output logic              intr_ready,
  output logic [3:0]        count,
  output logic [BYTE_W-1:0] data_out1,
  output logic              intr_ready_r,
  output logic              intr_ready_2r,
  output logic              intr_ready_3r,
  output logic              rsc1_in1,
  output logic              rsc_in2,
  output logic              sys_in,
  output logic              parity1,
  output logic              parity2,
  output logic [2:0]        encoded_data
);

  logic [BYTE_W-1:0] shift_r;
  logic [BYTE_W-2:0] sh1_r;
  logic [BYTE_W-2:0] sh2_r;
  logic [2:0]        ser_cnt_r;
  logic              active_r;
  logic              u1_s;
  logic              u2_s;
  logic              clear_s;

  // deserialiser: shift in MSB first, capture on the 8th bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r    <= '0;
      count      <= 4'd0;
      data_out   <= '0;
      byte_valid <= 1'b0;
    end else begin
      shift_r <= {shift_r[BYTE_W-2:0], serial_in};
      if (count == 4'd7) begin
        count      <= 4'd0;
        data_out   <= {shift_r[BYTE_W-2:0], serial_in};
        byte_valid <= 1'b1;
      end else begin
        count      <= count + 4'd1;
        byte_valid <= 1'b0;
      end
    end
  end

  // interleaver register and ready delay chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      intr          <= '0;
      intr_ready    <= 1'b0;
      intr_ready_r  <= 1'b0;
      intr_ready_2r <= 1'b0;
      intr_ready_3r <= 1'b0;
    end else begin
      if (byte_valid) begin
        intr <= interleave(data_out);
      end else begin
        intr <= intr;
      end
      intr_ready    <= byte_valid;
      intr_ready_r  <= intr_ready;
      intr_ready_2r <= intr_ready_r;
      intr_ready_3r <= intr_ready_2r;
    end
  end

  // serialiser: load MSB on intr_ready, then shift out the remaining 7 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out1 <= '0;
      rsc1_in1  <= 1'b0;
      rsc_in2   <= 1'b0;
      sh1_r     <= '0;
      sh2_r     <= '0;
      ser_cnt_r <= 3'd0;
      active_r  <= 1'b0;
    end else if (intr_ready) begin
      data_out1 <= data_out;
      rsc1_in1  <= data_out[BYTE_W-1];
      rsc_in2   <= intr[BYTE_W-1];
      sh1_r     <= data_out[BYTE_W-2:0];
      sh2_r     <= intr[BYTE_W-2:0];
      ser_cnt_r <= 3'd0;
      active_r  <= 1'b1;
    end else if (active_r && (ser_cnt_r != 3'd7)) begin
      rsc1_in1  <= sh1_r[BYTE_W-2];
      rsc_in2   <= sh2_r[BYTE_W-2];
      sh1_r     <= {sh1_r[BYTE_W-3:0], 1'b0};
      sh2_r     <= {sh2_r[BYTE_W-3:0], 1'b0};
      ser_cnt_r <= ser_cnt_r + 3'd1;
    end else begin
      active_r  <= 1'b0;
    end
  end

  // idle serialiser presents zero to the encoders; the held output bit stays visible
  assign u1_s = active_r & rsc1_in1;
  assign u2_s = active_r & rsc_in2;

`ifdef TURBO_TRELLIS_RESET_EN
  assign clear_s = intr_ready;
`else
  assign clear_s = 1'b0;
`endif

  rsc_encoder u_rsc1 (
    .clk    (clk),
    .rst    (rst),
    .enable (active_r),
    .clear  (clear_s),
    .u      (u1_s),
    .parity (parity1)
  );

  rsc_encoder u_rsc2 (
    .clk    (clk),
    .rst    (rst),
    .enable (active_r),
    .clear  (clear_s),
    .u      (u2_s),
    .parity (parity2)
  );

  assign sys_in       = rsc1_in1;
  assign encoded_data = {sys_in, parity1, parity2};

endmodule

// File: tb/tb_turbo_encoder_top.sv
// Self-checking bench for turbo_encoder_top: directed spec vectors plus random byte
// streams checked cycle by cycle against a byte-level reference model.
module tb_turbo_encoder_top;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       byte_valid;
  logic [7:0] intr;
  logic       intr_ready;
  logic [3:0] count;
  logic [7:0] data_out1;
  logic       intr_ready_r;
  logic       intr_ready_2r;
  logic       intr_ready_3r;
  logic       rsc1_in1;
  logic       rsc_in2;
  logic       sys_in;
  logic       parity1;
  logic       parity2;
  logic [2:0] encoded_data;

  int checks;
  int failures;
  bit trellis_reset;

  logic [7:0] stream_q [$];
  logic       exp_p1 [$];
  logic       exp_p2 [$];

  turbo_encoder_top dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_out      (data_out),
    .byte_valid    (byte_valid),
    .intr          (intr),
    .intr_ready    (intr_ready),
    .count         (count),
    .data_out1     (data_out1),
    .intr_ready_r  (intr_ready_r),
    .intr_ready_2r (intr_ready_2r),
    .intr_ready_3r (intr_ready_3r),
    .rsc1_in1      (rsc1_in1),
    .rsc_in2       (rsc_in2),
    .sys_in        (sys_in),
    .parity1       (parity1),
    .parity2       (parity2),
    .encoded_data  (encoded_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference interleaver: output bit i takes input bit at the 3-bit reversal of i
  function automatic logic [7:0] ref_intr(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = d[(i % 2) * 4 + ((i / 2) % 2) * 2 + (i / 4)];
    end
    return r;
  endfunction

  // Parity streams from the recursion a_k = u_k ^ a_{k-1} ^ a_{k-2}, p_k = a_k ^ a_{k-2}
  task automatic build_model();
    logic a1m1, a1m2, a2m1, a2m2, a, u;
    logic [7:0] ib;
    exp_p1.delete();
    exp_p2.delete();
    a1m1 = 1'b0; a1m2 = 1'b0; a2m1 = 1'b0; a2m2 = 1'b0;
    for (int k = 0; k < stream_q.size(); k++) begin
      if (trellis_reset) begin
        a1m1 = 1'b0; a1m2 = 1'b0; a2m1 = 1'b0; a2m2 = 1'b0;
      end
      ib = ref_intr(stream_q[k]);
      for (int j = 7; j >= 0; j--) begin
        u = stream_q[k][j];
        a = u ^ a1m1 ^ a1m2;
        exp_p1.push_back(a ^ a1m2);
        a1m2 = a1m1; a1m1 = a;
        u = ib[j];
        a = u ^ a2m1 ^ a2m2;
        exp_p2.push_back(a ^ a2m2);
        a2m2 = a2m1; a2m1 = a;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_byte_valid"}, byte_valid, 0);
    chk({tag, "_intr"}, intr, 0);
    chk({tag, "_intr_ready"}, intr_ready, 0);
    chk({tag, "_data_out1"}, data_out1, 0);
    chk({tag, "_ready_chain"}, {intr_ready_r, intr_ready_2r, intr_ready_3r}, 0);
    chk({tag, "_serial_bits"}, {rsc1_in1, rsc_in2, sys_in}, 0);
    chk({tag, "_encoded"}, encoded_data, 0);
  endtask

  // Feed stream_q from a freshly reset DUT and check every output on every cycle
  task automatic run_stream(input bit check_third);
    int n, k, j;
    logic [7:0] ib;
    logic [7:0] sys_first, p1_first, p2_first;
    logic e_sys, e_ri2, e_p1, e_p2;
    sys_first = 8'b1010_1000;
    p1_first  = 8'b1101_1000;
    p2_first  = 8'b1010_0000;
    n = stream_q.size();
    build_model();
    for (int t = 1; t <= 8 * n; t++) begin
      serial_in = stream_q[(t - 1) / 8][7 - ((t - 1) % 8)];
      @(posedge clk);
      #1;
      chk("count", count, t % 8);
      chk("byte_valid", byte_valid, (t % 8 == 0) ? 1 : 0);
      chk("data_out", data_out, (t >= 8) ? stream_q[t / 8 - 1] : 8'h00);
      chk("intr_ready", intr_ready, (t >= 9 && t % 8 == 1) ? 1 : 0);
      chk("intr", intr, (t >= 9) ? ref_intr(stream_q[(t - 1) / 8 - 1]) : 8'h00);
      chk("intr_ready_r", intr_ready_r, (t >= 10 && t % 8 == 2) ? 1 : 0);
      chk("intr_ready_2r", intr_ready_2r, (t >= 11 && t % 8 == 3) ? 1 : 0);
      chk("intr_ready_3r", intr_ready_3r, (t >= 12 && t % 8 == 4) ? 1 : 0);
      if (t >= 10) begin
        k = (t - 10) / 8;
        j = (t - 10) % 8;
        ib = ref_intr(stream_q[k]);
        e_sys = stream_q[k][7 - j];
        e_ri2 = ib[7 - j];
        e_p1  = exp_p1[8 * k + j];
        e_p2  = exp_p2[8 * k + j];
        chk("data_out1", data_out1, stream_q[k]);
      end else begin
        e_sys = 1'b0; e_ri2 = 1'b0; e_p1 = 1'b0; e_p2 = 1'b0;
        chk("data_out1", data_out1, 8'h00);
      end
      chk("rsc1_in1", rsc1_in1, e_sys);
      chk("rsc_in2", rsc_in2, e_ri2);
      chk("sys_in", sys_in, e_sys);
      chk("parity1", parity1, e_p1);
      chk("parity2", parity2, e_p2);
      chk("encoded_data", encoded_data, {e_sys, e_p1, e_p2});
      // Literal vectors for the leading 0xA8 byte
      if (t == 8) chk("first_data_out", data_out, 8'hA8);
      if (t == 9) chk("first_intr", intr, 8'hE0);
      if (t == 10) chk("first_encoded", encoded_data, 3'b111);
      if (t >= 10 && t < 18) begin
        chk("first_sys", sys_in, sys_first[17 - t]);
        chk("first_parity1", parity1, p1_first[17 - t]);
        chk("first_parity2", parity2, p2_first[17 - t]);
      end
      if (check_third && t == 25) chk("third_intr", intr, 8'hF0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
`ifdef TURBO_TRELLIS_RESET_EN
    trellis_reset = 1'b1;
`else
    trellis_reset = 1'b0;
`endif
    rst = 1'b0;
    serial_in = 1'b0;

    // Reset held with random input
    for (int i = 0; i < 6; i++) begin
      serial_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk_all_zero("reset");
    chk("reset_parity", {parity1, parity2}, 0);
    rst = 1'b1;

    // 0xA8, 0xEB, 0xAA then random bytes, with a trailing byte that only feeds the pipe
    stream_q = '{8'hA8, 8'hEB, 8'hAA};
    for (int i = 0; i < 5; i++) stream_q.push_back(8'($urandom));
    run_stream(1'b1);

    // Mid-byte reset after 4 bits
    for (int i = 0; i < 4; i++) begin
      serial_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk("pre_reset_count", count, 4);
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    #1;
    chk("midreset_hold_count", count, 0);
    rst = 1'b1;

    // Fresh stream must reproduce the first-byte results
    stream_q = '{8'hA8, 8'($urandom), 8'($urandom), 8'($urandom)};
    run_stream(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
